mul_unit: RTL and testbench
===========================

// Module: mul_unit
// PURPOSE
//   Iterative RV32M multiplier for MUL/MULH/MULHSU/MULHU (opcode 0110011, funct7 0000001).
//   Sits beside the execute-stage ALU, which drives 0 for the M-extension encodings.
//   Takes the same src_A/src_B/instruction operands and returns the 32-bit product word
//   to the writeback mux through a start/busy/done handshake.
// PARAMETERS
//   XLEN    32  operand/result width
//   UNROLL  1   multiplier bits retired per CALC cycle; legal 1,2,4,8; XLEN%UNROLL==0
// PORTS
//   clk          in   1     system clock, rising edge
//   n_rst        in   1     asynchronous active-low reset
//   start        in   1     request: operands + instruction valid this cycle
//   flush        in   1     abort any operation in flight (pipeline flush)
//   src_A        in   XLEN  rs1 value (multiplicand)
//   src_B        in   XLEN  rs2 value (multiplier)
//   instruction  in   32    full instruction word; op decoded from [31:25],[14:12],[6:0]
//   busy         out  1     operation in progress; start ignored
//   done         out  1     one-cycle pulse: result valid
//   result       out  XLEN  product word; held until next done
// BEHAVIOUR
//   Reset (n_rst=0, async): state=IDLE; busy=0; done=0; result=0; internal regs=0.
//   Accept: start=1 && state==IDLE && !flush && opcode==0110011 && funct7==0000001
//     && funct3[2]==0. Other encodings (DIV/REM, non-M) are ignored: no busy, no done.
//   Op (funct3): 000 MUL=prod[31:0]; 001 MULH s*s [63:32]; 010 MULHSU s*u [63:32];
//     011 MULHU u*u [63:32]. MUL is computed unsigned (low word is sign-independent).
//   Sign handling: on accept, latch |A| if A is signed for the op, else A raw; same for B.
//     neg = signA ^ signB over the signed operands only. |0x80000000| = 0x80000000 unsigned.
//   FSM: IDLE -> CALC (on accept); CALC -> DONE after N=XLEN/UNROLL cycles;
//     DONE -> IDLE (always, 1 cycle).
//   CALC: each cycle add (mcand << k) for each set bit of the low UNROLL multiplier bits
//     into a 2*XLEN accumulator; shift the multiplier right by UNROLL; count++.
//     All arithmetic is 2*XLEN unsigned, with no overflow loss.
//   On the CALC->DONE edge: result <= half-select(neg ? -acc : acc). done=1 in DONE only.
//   busy=1 in CALC and DONE, 0 in IDLE. Latency: accept edge to done high = N+1 cycles
//     (33 at default). Throughput: next accept earliest in the IDLE cycle after DONE.
//   flush=1 in CALC or DONE: next state IDLE, done forced 0 that cycle, result unchanged.
//     flush and start together in IDLE: flush wins, no accept.
//   start while busy: ignored; operands are not re-latched.
//   Operands are latched at accept; src_A/src_B/instruction may change during CALC.
// STRUCTURE
//   rv32_pkg (shared): OPC_OP=7'b0110011, F7_MULDIV=7'b0000001,
//     typedef enum logic[1:0] {MUL_LO,MULH_SS,MULH_SU,MULH_UU} mul_op_t,
//     typedef enum logic[1:0] {IDLE,CALC,DONE} mul_state_t.
//   Sub-module mul_step: combinational UNROLL-bit partial-product accumulate
//     (acc, mcand, mplier_bits -> acc_next). FSM, counter, sign fix-up and result reg
//     live in mul_unit.
// TESTING
//   MUL 7 * 0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 33 cycles after accept, 1 cycle wide.
//   MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//   MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF; MULH 0xFFFFFFFF*0x00000001 -> 0xFFFFFFFF.
//   Flush 10 cycles into CALC -> no done, busy=0 next cycle, result keeps old value;
//     then a fresh MUL 3*5 -> 0x0000000F.
//   Start while busy and start with funct3=100 (DIV) both ignored; n_rst low mid-CALC
//     -> busy=0, done=0, result=0 immediately.
//   UNROLL=4: MULHU 0x12345678*0x9ABCDEF0 -> 0x0B00EA4E, done 9 cycles after accept.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 decode constants and the multiplier's op/state encodings.
package rv32_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   typedef enum logic [1:0] {
      MUL_LO,
      MULH_SS,
      MULH_SU,
      MULH_UU
   } mul_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } mul_state_t;

endpackage

// File: rtl/mul_step.sv
// One iteration of the shift-add multiplier: adds the multiplicand, shifted
// by each set bit position of the low multiplier bits, into the accumulator.
module mul_step #(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned UNROLL = 1
) (
   input  logic [2*XLEN-1:0] acc,
   input  logic [2*XLEN-1:0] mcand,
   input  logic [UNROLL-1:0] mplier_bits,
   output logic [2*XLEN-1:0] acc_next
);

   // Partial-product accumulate over UNROLL multiplier bits.
   always_comb begin
      acc_next = acc;
      for (int unsigned k = 0; k < UNROLL; k++) begin
         if (mplier_bits[k]) begin
            acc_next = acc_next + (mcand << k);
         end
      end
   end

endmodule

// File: rtl/mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) with start/busy/done
// handshake. Operands are reduced to magnitudes on accept, multiplied
// unsigned over XLEN/UNROLL cycles, and the sign is restored at the end.
module mul_unit
   import rv32_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned UNROLL = 1
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            start,
   input  logic            flush,
   input  logic [XLEN-1:0] src_A,
   input  logic [XLEN-1:0] src_B,
   input  logic [31:0]     instruction,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned N  = XLEN / UNROLL;
   localparam int unsigned CW = $clog2(N) + 1;

   mul_state_t          r_state;
   mul_state_t          w_state_next;
   mul_op_t             r_op;
   logic [2*XLEN-1:0]   r_acc;
   logic [2*XLEN-1:0]   r_mcand;
   logic [XLEN-1:0]     r_mplier;
   logic [CW-1:0]       r_cnt;
   logic                r_neg;
   logic [XLEN-1:0]     r_result;

   mul_op_t             w_op;
   logic                w_accept;
   logic                w_sign_a;
   logic                w_sign_b;
   logic                w_neg_a;
   logic                w_neg_b;
   logic [XLEN-1:0]     w_abs_a;
   logic [XLEN-1:0]     w_abs_b;
   logic [2*XLEN-1:0]   w_acc_next;
   logic [2*XLEN-1:0]   w_prod;
   logic [XLEN-1:0]     w_final;
   logic                w_calc_last;
   logic                w_unused;

   // Register fields are irrelevant to the multiplier.
   assign w_unused = ^{instruction[24:15], instruction[11:7]};

   assign w_op     = mul_op_t'(instruction[13:12]);
   assign w_accept = start && (r_state == IDLE) && !flush
                     && (instruction[6:0] == OPC_OP)
                     && (instruction[31:25] == F7_MULDIV)
                     && !instruction[14];

   // MUL takes the low word, which is the same for signed and unsigned.
   assign w_sign_a = (w_op == MULH_SS) || (w_op == MULH_SU);
   assign w_sign_b = (w_op == MULH_SS);
   assign w_neg_a  = w_sign_a && src_A[XLEN-1];
   assign w_neg_b  = w_sign_b && src_B[XLEN-1];
   assign w_abs_a  = w_neg_a ? (-src_A) : src_A;
   assign w_abs_b  = w_neg_b ? (-src_B) : src_B;

   assign w_calc_last = (r_cnt == CW'(N - 1));

   mul_step #(
      .XLEN   (XLEN),
      .UNROLL (UNROLL)
   ) u_step (
      .acc         (r_acc),
      .mcand       (r_mcand),
      .mplier_bits (r_mplier[UNROLL-1:0]),
      .acc_next    (w_acc_next)
   );

   // Final step's sum is used directly so the result lands on the CALC->DONE edge.
   assign w_prod  = r_neg ? (-w_acc_next) : w_acc_next;
   assign w_final = (r_op == MUL_LO) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   assign result = r_result;

   // Next-state and handshake outputs.
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) w_state_next = CALC;
         end
         CALC: begin
            busy = 1'b1;
            if (flush)            w_state_next = IDLE;
            else if (w_calc_last) w_state_next = DONE;
         end
         DONE: begin
            busy         = 1'b1;
            done         = !flush;
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // State, operand latch, iteration datapath and result register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state  <= IDLE;
         r_op     <= MUL_LO;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_op     <= w_op;
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_cnt    <= '0;
            r_neg    <= w_neg_a ^ w_neg_b;
         end else if (r_state == CALC) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << UNROLL;
            r_mplier <= r_mplier >> UNROLL;
            r_cnt    <= r_cnt + CW'(1);
            if (w_calc_last && !flush) r_result <= w_final;
         end
      end
   end

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: default (UNROLL=1) and UNROLL=4 instances.
module tb_mul_unit;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start, start4, flush;
   logic [31:0] src_A, src_B, instruction;
   logic        busy, done, busy4, done4;
   logic [31:0] result, result4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mul_unit #(.XLEN(32), .UNROLL(1)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .flush(flush),
      .src_A(src_A), .src_B(src_B), .instruction(instruction),
      .busy(busy), .done(done), .result(result)
   );

   mul_unit #(.XLEN(32), .UNROLL(4)) dut4 (
      .clk(clk), .n_rst(n_rst), .start(start4), .flush(flush),
      .src_A(src_A), .src_B(src_B), .instruction(instruction),
      .busy(busy4), .done(done4), .result(result4)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_ins(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   // Issue one op at #1 after an edge, scramble inputs during CALC, optionally
   // poke start at cycle 'poke', then check latency, result and pulse width.
   task automatic run_op(input bit u4, input string tag, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] f3,
                         input logic [31:0] exp, input int exp_lat, input int poke);
      int cyc;
      src_A = a; src_B = b; instruction = mk_ins(7'b0000001, f3);
      if (u4) start4 = 1'b1; else start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; start4 = 1'b0;
      src_A = $urandom; src_B = $urandom; instruction = $urandom;
      cyc = 1;
      while (!(u4 ? done4 : done) && cyc < 100) begin
         if (cyc == poke) begin
            src_A = 32'hFFFF_FFFF; src_B = 32'hFFFF_FFFF;
            instruction = mk_ins(7'b0000001, 3'b011);
            if (u4) start4 = 1'b1; else start = 1'b1;
         end else begin
            start = 1'b0; start4 = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start = 1'b0; start4 = 1'b0;
      check({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
      check({tag, "_res"}, u4 ? result4 : result, exp);
      @(posedge clk); #1;
      check({tag, "_pulse"}, 32'(u4 ? done4 : done), 32'd0);
      check({tag, "_idle"}, 32'(u4 ? busy4 : busy), 32'd0);
   endtask

   // Hold inputs idle for n cycles and count done pulses seen.
   task automatic count_done(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
   endtask

   initial begin
      int pulses;
      n_rst = 1'b0; start = 1'b0; start4 = 1'b0; flush = 1'b0;
      src_A = '0; src_B = '0; instruction = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      n_rst = 1'b1;
      @(posedge clk); #1;

      run_op(0, "mul_neg",    32'd7,          32'hFFFF_FFFD, 3'b000, 32'hFFFF_FFEB, 33, 0);
      run_op(0, "mulh_min",   32'h8000_0000,  32'h8000_0000, 3'b001, 32'h4000_0000, 33, 0);
      run_op(0, "mulhu_max",  32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b011, 32'hFFFF_FFFE, 33, 0);
      run_op(0, "mulhsu_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF, 3'b010, 32'hFFFF_FFFF, 33, 0);
      run_op(0, "mulh_m1",    32'hFFFF_FFFF,  32'h0000_0001, 3'b001, 32'hFFFF_FFFF, 33, 0);
      run_op(0, "mulh_pos",   32'hFFFF_FFFE,  32'hFFFF_FFFD, 3'b001, 32'h0000_0000, 33, 0);
      run_op(0, "mul_wrap",   32'h0001_0000,  32'h0001_0000, 3'b000, 32'h0000_0000, 33, 0);
      run_op(0, "mul_big",    32'h0001_0001,  32'h0000_FFFF, 3'b000, 32'hFFFF_FFFF, 33, 0);

      // DIV and non-M encodings are ignored; result keeps 0xFFFFFFFF.
      src_A = 32'd100; src_B = 32'd7; instruction = mk_ins(7'b0000001, 3'b100);
      start = 1'b1;
      @(posedge clk); #1;
      check("div_busy", 32'(busy), 32'd0);
      instruction = mk_ins(7'b0000000, 3'b000);
      @(posedge clk); #1;
      start = 1'b0;
      check("add_busy", 32'(busy), 32'd0);
      count_done(40, pulses);
      check("ignored_done", 32'(pulses), 32'd0);
      check("ignored_res", result, 32'hFFFF_FFFF);

      // Flush and start together in IDLE: flush wins.
      src_A = 32'd3; src_B = 32'd5; instruction = mk_ins(7'b0000001, 3'b000);
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", 32'(busy), 32'd0);

      // Flush 10 cycles into CALC.
      src_A = 32'd9; src_B = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("pre_flush_busy", 32'(busy), 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", 32'(busy), 32'd0);
      check("flush_done", 32'(done), 32'd0);
      check("flush_res", result, 32'hFFFF_FFFF);
      count_done(40, pulses);
      check("flush_no_done", 32'(pulses), 32'd0);
      run_op(0, "mul_3x5", 32'd3, 32'd5, 3'b000, 32'h0000_000F, 33, 0);

      // Start while busy is ignored (no re-latch, latency unchanged).
      run_op(0, "busy_start", 32'h0000_1234, 32'h0000_0010, 3'b000, 32'h0001_2340, 33, 5);

      // Asynchronous reset mid-CALC.
      src_A = 32'd11; src_B = 32'd13; instruction = mk_ins(7'b0000001, 3'b000);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      n_rst = 1'b0;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_res", result, 32'd0);
      n_rst = 1'b1;
      @(posedge clk); #1;

      // UNROLL=4 instance.
      run_op(1, "mulhu_u4", 32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 32'h0B00_EA4E, 9, 0);
      run_op(1, "mul_u4",   32'd7,         32'hFFFF_FFFD, 3'b000, 32'hFFFF_FFEB, 9, 0);
      run_op(1, "mulh_u4",  32'h8000_0000, 32'h8000_0000, 3'b001, 32'h4000_0000, 9, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
